// File: rtl/sound_pkg.sv
// Shared types and constants for the sound-to-LED frame scheduler.
package sound_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  localparam logic [3:0] AN_DIG0 = 4'b1110;
  localparam logic [3:0] AN_DIG1 = 4'b1101;
  localparam logic [3:0] AN_DIG2 = 4'b1011;
  localparam logic [3:0] AN_DIG3 = 4'b0111;

  localparam int FRAME_BITS_DEF = 8;

endpackage

// File: rtl/sound_frame_scheduler_tick_divider.sv
// Free-running clock-enable generator: tick is high for one cycle every DIV+1 cycles.
module tick_divider #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DIV > 0) ? $clog2(DIV + 1) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == CW'(DIV)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == CW'(DIV));

endmodule

// File: rtl/sound_frame_scheduler.sv
// Single-clock sound sampler: assembles aout samples into frames, commits them to the LED bar
// and scans the anodes. Define PEAK_HOLD_EN to hold peaks for HOLD_FRAMES commits.
module sound_frame_scheduler
  import sound_pkg::*;
#(
  parameter int SAMPLE_DIV  = 6944,
  parameter int SCAN_DIV    = 100000,
  parameter int FRAME_BITS  = FRAME_BITS_DEF,
  parameter int HOLD_FRAMES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  aout,
  input  logic                  dout,
  output logic [FRAME_BITS-1:0] led,
  output logic                  frame_valid,
  output logic                  sound_det,
  output logic [3:0]            an,
  output logic                  sample_tick,
  output logic                  scan_tick,
  output logic                  busy,
  output state_t                state
);

  localparam int BW = $clog2(FRAME_BITS + 1);

  logic                  aout_m;
  logic                  aout_s;
  logic                  dout_m;
  state_t                state_next;
  logic [BW-1:0]         bit_cnt;
  logic [BW-1:0]         bit_cnt_next;
  logic [FRAME_BITS-1:0] shift_reg;
  logic [FRAME_BITS-1:0] shift_next;
  logic                  commit;

  tick_divider #(.DIV(SAMPLE_DIV)) u_sample_div (
    .clk  (clk),
    .rst  (rst),
    .tick (sample_tick)
  );

  tick_divider #(.DIV(SCAN_DIV)) u_scan_div (
    .clk  (clk),
    .rst  (rst),
    .tick (scan_tick)
  );

  // Two-flop synchronizers for the asynchronous comparator and detector bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aout_m    <= 1'b0;
      aout_s    <= 1'b0;
      dout_m    <= 1'b0;
      sound_det <= 1'b0;
    end else begin
      aout_m    <= aout;
      aout_s    <= aout_m;
      dout_m    <= dout;
      sound_det <= dout_m;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an <= AN_DIG0;
    end else if (scan_tick) begin
      case (an)
        AN_DIG0: an <= AN_DIG1;
        AN_DIG1: an <= AN_DIG2;
        AN_DIG2: an <= AN_DIG3;
        default: an <= AN_DIG0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      state     <= state_next;
      bit_cnt   <= bit_cnt_next;
      shift_reg <= shift_next;
    end
  end

  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    shift_next   = shift_reg;
    commit       = 1'b0;
    case (state)
      IDLE: begin
        bit_cnt_next = '0;
        if (en) state_next = CAPTURE;
      end
      CAPTURE: begin
        if (!en) begin
          // Abort: partial frame is dropped, the LED bar keeps the last commit.
          state_next   = IDLE;
          bit_cnt_next = '0;
        end else if (sample_tick) begin
          shift_next   = {shift_reg[FRAME_BITS-2:0], aout_s};
          bit_cnt_next = bit_cnt + 1'b1;
          if (bit_cnt == BW'(FRAME_BITS - 1)) state_next = COMMIT;
        end
      end
      COMMIT: begin
        commit       = 1'b1;
        bit_cnt_next = '0;
        state_next   = en ? CAPTURE : IDLE;
      end
      default: begin
        state_next   = IDLE;
        bit_cnt_next = '0;
      end
    endcase
  end

  assign frame_valid = (state == COMMIT);
  assign busy        = (state == CAPTURE) && (bit_cnt != '0);

`ifdef PEAK_HOLD_EN
  localparam int HW = $clog2(HOLD_FRAMES + 1);

  logic [HW-1:0] hold_cnt;

  // New lit bits stick immediately; a quieter frame only replaces the bar after the hold expires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led      <= '0;
      hold_cnt <= '0;
    end else if (commit) begin
      if ((shift_reg & ~led) != '0) begin
        led      <= led | shift_reg;
        hold_cnt <= '0;
      end else if (hold_cnt == HW'(HOLD_FRAMES - 1)) begin
        led      <= shift_reg;
        hold_cnt <= '0;
      end else begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led <= '0;
    end else if (commit) begin
      led <= shift_reg;
    end
  end
`endif

endmodule

// File: tb/tb_sound_frame_scheduler.sv
// Directed bench for sound_frame_scheduler with short dividers (SAMPLE_DIV=3, SCAN_DIV=2).
module tb_sound_frame_scheduler;
  import sound_pkg::*;

  logic       clk;
  logic       rst;
  logic       en;
  logic       aout;
  logic       dout;
  logic [7:0] led;
  logic       frame_valid;
  logic       sound_det;
  logic [3:0] an;
  logic       sample_tick;
  logic       scan_tick;
  logic       busy;
  state_t     state;

  int n_checks = 0;
  int n_errors = 0;

  sound_frame_scheduler #(
    .SAMPLE_DIV  (3),
    .SCAN_DIV    (2),
    .FRAME_BITS  (8),
    .HOLD_FRAMES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .aout        (aout),
    .dout        (dout),
    .led         (led),
    .frame_valid (frame_valid),
    .sound_det   (sound_det),
    .an          (an),
    .sample_tick (sample_tick),
    .scan_tick   (scan_tick),
    .busy        (busy),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_tick();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (sample_tick) break;
    end
    check("sample_tick_seen", 32'(sample_tick), 32'd1);
  endtask

  task automatic wait_scan_tick();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (scan_tick) break;
    end
    check("scan_tick_seen", 32'(scan_tick), 32'd1);
  endtask

  // Sends one frame MSB first; the first bit sampled ends up in led[7].
  task automatic run_frame(input logic [7:0] f, input logic [7:0] exp_led);
    for (int i = 7; i >= 0; i--) begin
      aout = f[i];
      wait_tick();
    end
    @(negedge clk);
    check("commit_pulse", 32'(frame_valid), 32'd1);
    check("commit_state", 32'(state), 32'(COMMIT));
    @(negedge clk);
    check("pulse_one_cycle", 32'(frame_valid), 32'd0);
    check("led_after_commit", 32'(led), 32'(exp_led));
    check("busy_after_commit", 32'(busy), 32'd0);
  endtask

  logic [3:0] an_seq [4];
  int         pos[$];
  int         n;
  int         idx;

  initial begin
    an_seq = '{AN_DIG0, AN_DIG1, AN_DIG2, AN_DIG3};
    rst = 1'b1; en = 1'b0; aout = 1'b0; dout = 1'b0;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    check("rst_led", 32'(led), 32'd0);
    check("rst_an", 32'(an), 32'hE);
    check("rst_state", 32'(state), 32'(IDLE));
    check("rst_frame_valid", 32'(frame_valid), 32'd0);
    check("rst_sample_tick", 32'(sample_tick), 32'd0);
    check("rst_scan_tick", 32'(scan_tick), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sound_det", 32'(sound_det), 32'd0);
    rst = 1'b0;

    // Frame capture: samples 1,0,1,1,0,0,1,0
    wait_tick();
    en = 1'b1;
    run_frame(8'b1011_0010, 8'b1011_0010);

    // Contiguous frames: 24 more ticks with aout held high
    aout = 1'b1;
    for (int i = 1; i <= 96; i++) begin
      @(negedge clk);
      if (frame_valid) pos.push_back(i);
    end
    check("contig_pulse_count", 32'(pos.size()), 32'd3);
    if (pos.size() == 3) begin
      check("contig_first_pos", 32'(pos[0]), 32'd31);
      check("contig_gap1", 32'(pos[1] - pos[0]), 32'd32);
      check("contig_gap2", 32'(pos[2] - pos[1]), 32'd32);
    end
    check("contig_led", 32'(led), 32'hFF);

    // Abort after 5 ticks, re-raise 10 cycles later
    aout = 1'b0;
    for (int i = 0; i < 5; i++) wait_tick();
    en = 1'b0;
    aout = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("abort_state", 32'(state), 32'(IDLE));
      check("abort_no_commit", 32'(frame_valid), 32'd0);
      check("abort_led_held", 32'(led), 32'hFF);
    end
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_tick();
      check("reraise_no_early_commit", 32'(frame_valid), 32'd0);
    end
    @(negedge clk);
    check("reraise_commit", 32'(frame_valid), 32'd1);
    @(negedge clk);
    check("reraise_led", 32'(led), 32'hFF);

    // Reset mid-frame with bit_cnt == 5
    for (int i = 0; i < 5; i++) wait_tick();
    @(negedge clk);
    check("busy_mid_frame", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_an", 32'(an), 32'hE);
    check("midrst_led", 32'(led), 32'd0);
    check("midrst_state", 32'(state), 32'(IDLE));
    check("midrst_busy", 32'(busy), 32'd0);
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      n = i;
      if (sample_tick) break;
    end
    // Release cycle holds count 0, so the tick lands in the fourth cycle.
    check("first_tick_latency", 32'(n), 32'd3);

    // Anode scan from a fresh reset
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idx = 0;
    check("scan_start_an", 32'(an), 32'(an_seq[0]));
    for (int k = 0; k < 8; k++) begin
      wait_scan_tick();
      @(negedge clk);
      idx = (idx + 1) % 4;
      check("scan_an", 32'(an), 32'(an_seq[idx]));
    end

    // dout synchronizer latency
    @(negedge clk);
    dout = 1'b1;
    @(negedge clk);
    check("sound_det_1cyc", 32'(sound_det), 32'd0);
    @(negedge clk);
    check("sound_det_2cyc", 32'(sound_det), 32'd1);

    // Frame sequence F0, 10, 10, 01
    wait_tick();
    en = 1'b1;
`ifdef PEAK_HOLD_EN
    run_frame(8'hF0, 8'hF0);
    run_frame(8'h10, 8'hF0);
    run_frame(8'h10, 8'h10);
    run_frame(8'h01, 8'h11);
`else
    run_frame(8'hF0, 8'hF0);
    run_frame(8'h10, 8'h10);
    run_frame(8'h10, 8'h10);
    run_frame(8'h01, 8'h01);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
